// File: rtl/input_event_pkg.sv
// Shared definitions for the input event interrupt front end:
// register map, source numbering and event FIFO entry layout.
package input_event_pkg;

  localparam int NUM_SOURCES  = 14;
  localparam int NUM_BUTTONS  = 4;
  localparam int NUM_SWITCHES = 10;
  localparam int SRC_BTN0     = 0;
  localparam int SRC_SW0      = 4;

  localparam logic [2:0] ADDR_PENDING   = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_CONFIG    = 3'd2;
  localparam logic [2:0] ADDR_LEVEL     = 3'd3;
  localparam logic [2:0] ADDR_FIFO_DATA = 3'd4;
  localparam logic [2:0] ADDR_FIFO_STAT = 3'd5;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd6;

  localparam int VALID_BIT = 31;
  localparam int KIND_BIT  = 20;
  localparam int SRC_LSB   = 16;
  localparam int TS_LSB    = 0;

  localparam int CFG_REL_EN     = 0;
  localparam int CFG_IRQ_EN     = 1;
  localparam int STAT_FLUSH_BIT = 0;
  localparam int STAT_OVF_BIT   = 8;

  function automatic logic [31:0] make_entry(input logic kind, input logic [3:0] src,
                                             input logic [15:0] ts);
    logic [31:0] e;
    e              = '0;
    e[VALID_BIT]   = 1'b1;
    e[KIND_BIT]    = kind;
    e[SRC_LSB +: 4] = src;
    e[TS_LSB +: 16] = ts;
    return e;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with flush; push while full and pop while empty are ignored.
module event_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      push_data,
  output logic [WIDTH-1:0]      head,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == (LOG2_DEPTH+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/input_event_irq.sv
// Avalon-MM event front end: edge detection on buttons/switches, W1C pending
// with mask, timestamped event log FIFO and a single level interrupt.
module input_event_irq
  import input_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int TS_WIDTH   = 16,
  parameter int PRESCALE   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_buttons,
  input  logic [9:0]  irq_switches,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [NUM_BUTTONS-1:0] prev_buttons_q, prev_buttons_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [1:0]             config_q, config_d;
  logic [NUM_SOURCES-1:0] stage_q, stage_d;
  logic [NUM_SOURCES-1:0] stage_kind_q, stage_kind_d;
  logic                   overflow_q, overflow_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [31:0]            readdata_q, readdata_d;
  logic                   irq_q, irq_d;

  logic [NUM_BUTTONS-1:0] press, rel_ev;
  logic [NUM_SOURCES-1:0] ev, ev_kind, grant, keep, w1c;
  logic [3:0]             grant_src;
  logic                   push_valid, flush, wr_stat, fifo_pop;
  logic [31:0]            push_entry, fifo_head;
  logic [LOG2_DEPTH:0]    fifo_count;
  logic                   fifo_full, fifo_empty;
  logic                   unused_wdata;

  assign unused_wdata = ^avs_writedata[31:NUM_SOURCES];

  event_fifo #(
    .WIDTH      (32),
    .DEPTH      (FIFO_DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .pop       (fifo_pop),
    .flush     (flush),
    .push_data (push_entry),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    press   = irq_buttons & ~prev_buttons_q;
    rel_ev  = ~irq_buttons & prev_buttons_q & {NUM_BUTTONS{config_q[CFG_REL_EN]}};
    ev      = {irq_switches, press | rel_ev};
    ev_kind = {{NUM_SWITCHES{1'b1}}, press};

    wr_stat = avs_write && (avs_address == ADDR_FIFO_STAT);
    flush   = wr_stat && avs_writedata[STAT_FLUSH_BIT];
    w1c     = (avs_write && (avs_address == ADDR_PENDING)) ? avs_writedata[NUM_SOURCES-1:0] : '0;

    // Lowest-index staged source is logged this cycle.
    grant     = stage_q & (~stage_q + 1'b1);
    grant_src = '0;
    for (int i = NUM_SOURCES-1; i >= 0; i--) begin
      if (stage_q[i]) grant_src = 4'(i);
    end
    push_valid = |stage_q;
    push_entry = make_entry(stage_kind_q[grant_src], grant_src, 16'(ts_q));

    // A staged event still waiting after this cycle blocks a new one on that source.
    keep         = flush ? '0 : (stage_q & ~grant);
    stage_d      = keep | ev;
    stage_kind_d = (stage_kind_q & ~(ev & ~keep)) | (ev_kind & ev & ~keep);

    overflow_d = (|(ev & keep)) | (push_valid & fifo_full & ~flush) |
                 (overflow_q & ~(wr_stat & avs_writedata[STAT_OVF_BIT]));

    pending_d      = (pending_q & ~w1c) | ev;
    prev_buttons_d = irq_buttons;

    mask_d   = mask_q;
    config_d = config_q;
    if (avs_write && (avs_address == ADDR_MASK))   mask_d   = avs_writedata[NUM_SOURCES-1:0];
    if (avs_write && (avs_address == ADDR_CONFIG)) config_d = avs_writedata[1:0];

    if (pre_q == PRE_W'(PRESCALE-1)) begin
      pre_d = '0;
      ts_d  = ts_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
      ts_d  = ts_q;
    end

    readdata_d = readdata_q;
    fifo_pop   = 1'b0;
    if (avs_read) begin
      case (avs_address)
        ADDR_PENDING:   readdata_d = 32'(pending_q);
        ADDR_MASK:      readdata_d = 32'(mask_q);
        ADDR_CONFIG:    readdata_d = 32'(config_q);
        ADDR_LEVEL:     readdata_d = 32'(irq_buttons);
        ADDR_FIFO_DATA: begin
          readdata_d = fifo_empty ? '0 : fifo_head;
          fifo_pop   = ~fifo_empty;
        end
        ADDR_FIFO_STAT: readdata_d = 32'(fifo_count) | (32'(overflow_q) << STAT_OVF_BIT);
        ADDR_TIMESTAMP: readdata_d = 32'(ts_q);
        default:        readdata_d = '0;
      endcase
    end

    irq_d = config_q[CFG_IRQ_EN] & (|(pending_q & mask_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_buttons_q <= '0;
      pending_q      <= '0;
      mask_q         <= '0;
      config_q       <= '0;
      stage_q        <= '0;
      stage_kind_q   <= '0;
      overflow_q     <= 1'b0;
      pre_q          <= '0;
      ts_q           <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      prev_buttons_q <= prev_buttons_d;
      pending_q      <= pending_d;
      mask_q         <= mask_d;
      config_q       <= config_d;
      stage_q        <= stage_d;
      stage_kind_q   <= stage_kind_d;
      overflow_q     <= overflow_d;
      pre_q          <= pre_d;
      ts_q           <= ts_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_input_event_irq.sv
// Scoreboard bench for input_event_irq: expected read data is queued at issue
// and compared when the registered read data returns.
module tb_input_event_irq;
  import input_event_pkg::*;

  localparam int PRESCALE = 4;
  localparam int TS_WIDTH = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_buttons = '0;
  logic [9:0]  irq_switches = '0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  input_event_irq #(
    .FIFO_DEPTH (16),
    .LOG2_DEPTH (4),
    .TS_WIDTH   (TS_WIDTH),
    .PRESCALE   (PRESCALE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_buttons   (irq_buttons),
    .irq_switches  (irq_switches),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; the DUT timestamp is cyc/PRESCALE.
  int unsigned cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ts_of(input int unsigned c);
    return 32'((c / PRESCALE) % (1 << TS_WIDTH));
  endfunction

  function automatic logic [31:0] entry(input logic kind, input int src, input logic [31:0] ts);
    return 32'h8000_0000 | (32'(kind) << 20) | (32'(src) << 16) | ts;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    sb_q.push_back(e);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read = 1'b0;
    e = sb_q.pop_front();
    check(e.tag, avs_readdata, e.val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned c, c1, c2;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_rdata", avs_readdata, 32'h0);

    // Timestamp after 40 cycles at 4 cycles per tick
    repeat (40) tick();
    bus_read(ADDR_TIMESTAMP, 32'd10, "ts_40");
    bus_read(ADDR_PENDING, 32'h0, "reset_pending");
    bus_read(ADDR_FIFO_STAT, 32'h0, "reset_stat");

    // Button 0 press with mask and global enable
    bus_write(ADDR_MASK, 32'h0001);
    bus_write(ADDR_CONFIG, 32'h0002);
    bus_read(ADDR_MASK, 32'h0001, "mask_rb");
    bus_read(ADDR_CONFIG, 32'h0002, "config_rb");
    irq_buttons = 4'b0001;
    c = cyc;
    tick();
    check("irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_read(ADDR_PENDING, 32'h1, "pend_btn0");
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 0, ts_of(c + 1)), "entry_btn0");
    bus_read(ADDR_FIFO_STAT, 32'h0, "stat_after_pop");
    bus_write(ADDR_PENDING, 32'h1);
    tick();
    check("irq_clr", {31'b0, irq}, 32'h0);

    // Two switch pulses in one cycle are logged over two cycles, lowest first
    irq_switches = 10'h201;
    c = cyc;
    tick();
    irq_switches = '0;
    bus_read(ADDR_FIFO_STAT, 32'h0, "cnt_0");
    bus_read(ADDR_FIFO_STAT, 32'h1, "cnt_1");
    bus_read(ADDR_FIFO_STAT, 32'h2, "cnt_2");
    bus_read(ADDR_PENDING, 32'h2010, "pend_sw");
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 4, ts_of(c + 1)), "entry_sw0");
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 13, ts_of(c + 2)), "entry_sw9");

    // Release events only with release-enable set
    bus_write(ADDR_PENDING, 32'h3FFF);
    irq_buttons = 4'b0101;
    c = cyc;
    repeat (2) tick();
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 2, ts_of(c + 1)), "entry_btn2_press");
    bus_write(ADDR_PENDING, 32'h3FFF);
    irq_buttons = 4'b0000;
    repeat (3) tick();
    bus_read(ADDR_FIFO_STAT, 32'h0, "no_release_cnt");
    bus_read(ADDR_PENDING, 32'h0, "no_release_pend");
    bus_write(ADDR_CONFIG, 32'h0003);
    irq_buttons = 4'b0100;
    c1 = cyc;
    repeat (3) tick();
    irq_buttons = 4'b0000;
    c2 = cyc;
    repeat (3) tick();
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 2, ts_of(c1 + 1)), "entry_rel_press");
    bus_read(ADDR_FIFO_DATA, entry(1'b0, 2, ts_of(c2 + 1)), "entry_rel_release");
    bus_read(ADDR_PENDING, 32'h4, "pend_btn2");
    tick();
    check("rdata_hold", avs_readdata, 32'h4);
    check("irq_masked", {31'b0, irq}, 32'h0);

    // Seventeen events with no reads: sixteen logged, one dropped
    bus_write(ADDR_PENDING, 32'h3FFF);
    for (int i = 0; i < 10; i++) begin
      irq_switches = 10'(1 << i);
      tick();
    end
    irq_switches = '0;
    for (int b = 0; b < 3; b++) begin
      irq_buttons[b] = 1'b1;
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      irq_buttons[b] = 1'b0;
      tick();
    end
    irq_switches = 10'h001;
    tick();
    irq_switches = '0;
    repeat (3) tick();
    bus_read(ADDR_FIFO_STAT, 32'h110, "full_ovf");
    check("irq_full", {31'b0, irq}, 32'h1);
    bus_write(ADDR_FIFO_STAT, 32'h100);
    bus_read(ADDR_FIFO_STAT, 32'h010, "ovf_clr");
    bus_write(ADDR_FIFO_STAT, 32'h001);
    bus_read(ADDR_FIFO_STAT, 32'h000, "flush");
    bus_read(ADDR_FIFO_DATA, 32'h0, "empty_read");

    // Timestamp wrap at 2^TS_WIDTH ticks
    while (cyc < 16380) tick();
    bus_read(ADDR_TIMESTAMP, 32'd4095, "ts_max");
    repeat (3) tick();
    bus_read(ADDR_TIMESTAMP, 32'd0, "ts_wrap");

    // Reset with a populated FIFO and active irq; button 1 held through it
    bus_write(ADDR_PENDING, 32'h3FFF);
    bus_write(ADDR_MASK, 32'h0070);
    irq_switches = 10'h007;
    tick();
    irq_switches = '0;
    repeat (3) tick();
    check("irq_pre_reset", {31'b0, irq}, 32'h1);
    bus_read(ADDR_FIFO_STAT, 32'h3, "cnt_pre_reset");
    irq_buttons = 4'b0010;
    #2 reset = 1'b1;
    #1;
    check("reset_async_irq", {31'b0, irq}, 32'h0);
    check("reset_async_rdata", avs_readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus_read(ADDR_PENDING, 32'h0, "post_reset_pend0");
    bus_read(ADDR_FIFO_STAT, 32'h0, "post_reset_cnt0");
    bus_read(ADDR_FIFO_STAT, 32'h1, "post_reset_cnt1");
    bus_read(ADDR_PENDING, 32'h2, "post_reset_pend1");
    bus_read(ADDR_LEVEL, 32'h2, "level");
    bus_read(ADDR_FIFO_DATA, entry(1'b1, 1, 32'h0), "entry_held_btn1");
    bus_read(3'd7, 32'h0, "addr7");
    bus_read(ADDR_MASK, 32'h0, "post_reset_mask");
    check("post_reset_irq", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
